// File: rtl/counter_pkg.sv
// Shared definitions for the counter bank: default sizing, command op-codes
// and the scheduler state encoding.
package counter_pkg;

  localparam int DEF_NUM_CH  = 16;
  localparam int DEF_W       = 16;
  localparam int DEF_WRAP_AT = 65535;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/counter_wrap_inc.sv
// Combinational wrapping incrementer shared by all counter channels.
// Any value at or above wrap_at rolls to zero and raises wrap.
module counter_wrap_inc #(
  parameter int W = 16
) (
  input  logic [W-1:0] v,
  input  logic [W-1:0] wrap_at,
  output logic [W-1:0] next_v,
  output logic         wrap
);

  always_comb begin
    wrap   = (v >= wrap_at);
    next_v = wrap ? '0 : v + W'(1);
  end

endmodule

// File: rtl/counter_bank_scheduler.sv
// Bank of display counters swept once per tick through a single shared
// incrementer, with a valid/ready command port for per-channel control.
module counter_bank_scheduler
  import counter_pkg::*;
#(
  parameter int             NUM_CH  = DEF_NUM_CH,
  parameter int             W       = DEF_W,
  parameter logic [W-1:0]   WRAP_AT = W'(DEF_WRAP_AT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [$clog2(NUM_CH)-1:0]   cmd_ch,
  input  logic [W-1:0]                cmd_data,
  output logic [NUM_CH*W-1:0]         data_raw,
  output logic [NUM_CH-1:0]           run_mask,
  output logic [NUM_CH-1:0]           wrap_flags,
  output logic                        busy,
  output logic                        tick_overrun
);

  localparam int CH_W = $clog2(NUM_CH);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [W-1:0]      cnt_q [NUM_CH];
  logic [W-1:0]      cnt_d [NUM_CH];
  logic [NUM_CH-1:0] run_mask_q, run_mask_d;
  logic [NUM_CH-1:0] wrap_q, wrap_d;
  logic [W-1:0]      inc_next;
  logic              inc_wrap;
  logic              cmd_fire;

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q == SWEEP);
  assign cmd_fire     = cmd_valid && cmd_ready;
  assign run_mask     = run_mask_q;
  assign wrap_flags   = wrap_q;
  assign tick_overrun = overrun_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign data_raw[g*W +: W] = cnt_q[g];
  end

  counter_wrap_inc #(.W(W)) u_inc (
    .v      (cnt_q[idx_q]),
    .wrap_at(WRAP_AT),
    .next_v (inc_next),
    .wrap   (inc_wrap)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    run_mask_d = run_mask_q;
    wrap_d     = wrap_q;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d   = SWEEP;
          pending_d = 1'b0;
          idx_d     = '0;
        end
      end
      SWEEP: begin
        if (run_mask_q[idx_q]) begin
          cnt_d[idx_q] = inc_next;
          if (inc_wrap) wrap_d[idx_q] = 1'b1;
        end
        if (idx_q == CH_W'(NUM_CH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Pending is only one deep; a second tick during a sweep is dropped.
    if (tick) begin
      if ((state_q == SWEEP) && pending_q) overrun_d = 1'b1;
      else                                 pending_d = 1'b1;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (cmd_fire && (cmd_ch == CH_W'(i))) begin
        case (cmd_op)
          OP_START: run_mask_d[i] = 1'b1;
          OP_STOP:  run_mask_d[i] = 1'b0;
          OP_CLEAR: begin
            cnt_d[i]  = '0;
            wrap_d[i] = 1'b0;
          end
          default:  cnt_d[i] = (cmd_data > WRAP_AT) ? WRAP_AT : cmd_data;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      idx_q      <= '0;
      run_mask_q <= '1;
      wrap_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= W'(NUM_CH - 1 - i);
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      idx_q      <= idx_d;
      run_mask_q <= run_mask_d;
      wrap_q     <= wrap_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_counter_bank_scheduler.sv
// Self-checking bench for counter_bank_scheduler: two instances (full-range
// and WRAP_AT=9999) share stimulus and are compared against a reference model.
module tb_counter_bank_scheduler;
  import counter_pkg::*;

  localparam int NCH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [3:0]    cmd_ch;
  logic [15:0]   cmd_data;

  logic          ready0, ready9, busy0, busy9, ovr0, ovr9;
  logic [255:0]  data0, data9;
  logic [15:0]   run0, run9, wrap0, wrap9;

  int checks   = 0;
  int failures = 0;

  counter_bank_scheduler #(.NUM_CH(16), .W(16), .WRAP_AT(16'd65535)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .cmd_valid(cmd_valid),
    .cmd_ready(ready0), .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data),
    .data_raw(data0), .run_mask(run0), .wrap_flags(wrap0), .busy(busy0),
    .tick_overrun(ovr0)
  );

  counter_bank_scheduler #(.NUM_CH(16), .W(16), .WRAP_AT(16'd9999)) dut9 (
    .clk(clk), .reset(reset), .tick(tick), .cmd_valid(cmd_valid),
    .cmd_ready(ready9), .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data),
    .data_raw(data9), .run_mask(run9), .wrap_flags(wrap9), .busy(busy9),
    .tick_overrun(ovr9)
  );

  always #5 clk = ~clk;

  // Reference model: mpos is the channel the next edge will visit, -1 when idle.
  int  mval  [2][NCH];
  bit  mwrap [2][NCH];
  bit  mrun  [NCH];
  bit  mpend, movr;
  int  mpos;
  int  lim   [2] = '{65535, 9999};

  function automatic void modelReset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NCH; i++) begin
        mval[d][i]  = NCH - 1 - i;
        mwrap[d][i] = 1'b0;
      end
    for (int i = 0; i < NCH; i++) mrun[i] = 1'b1;
    mpend = 1'b0;
    movr  = 1'b0;
    mpos  = -1;
  endfunction

  function automatic void modelStep(bit t, bit v, logic [1:0] op, int ch, int data);
    bit sweeping = (mpos >= 0);
    bit oldpend  = mpend;
    int nextpos;
    if (!sweeping) begin
      nextpos = oldpend ? 0 : -1;
      if (oldpend) mpend = 1'b0;
    end else begin
      if (mrun[mpos])
        for (int d = 0; d < 2; d++) begin
          if (mval[d][mpos] >= lim[d]) begin
            mval[d][mpos]  = 0;
            mwrap[d][mpos] = 1'b1;
          end else begin
            mval[d][mpos] = mval[d][mpos] + 1;
          end
        end
      nextpos = (mpos == NCH - 1) ? -1 : mpos + 1;
    end
    if (t) begin
      if (sweeping && oldpend) movr = 1'b1;
      else                     mpend = 1'b1;
    end
    if (!sweeping && v && ch < NCH) begin
      for (int d = 0; d < 2; d++)
        case (op)
          OP_START: mrun[ch] = 1'b1;
          OP_STOP:  mrun[ch] = 1'b0;
          OP_CLEAR: begin mval[d][ch] = 0; mwrap[d][ch] = 1'b0; end
          default:  mval[d][ch] = (data > lim[d]) ? lim[d] : data;
        endcase
    end
    mpos = nextpos;
  endfunction

  function automatic logic [255:0] packVals(int base);
    logic [255:0] r;
    for (int i = 0; i < NCH; i++) r[i*16 +: 16] = 16'(base + NCH - 1 - i);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic compareOne(input string tag, input int d, input logic [255:0] data,
                            input logic [15:0] run, input logic [15:0] wrap,
                            input logic busyv, input logic ovr, input logic rdy);
    logic [255:0] ed;
    logic [15:0]  er, ew;
    for (int i = 0; i < NCH; i++) begin
      ed[i*16 +: 16] = 16'(mval[d][i]);
      er[i] = mrun[i];
      ew[i] = mwrap[d][i];
    end
    checkOutput($sformatf("%s/d%0d/data_raw", tag, d), data, ed);
    checkOutput($sformatf("%s/d%0d/run_mask", tag, d), 256'(run), 256'(er));
    checkOutput($sformatf("%s/d%0d/wrap_flags", tag, d), 256'(wrap), 256'(ew));
    checkOutput($sformatf("%s/d%0d/busy", tag, d), 256'(busyv), 256'(mpos >= 0));
    checkOutput($sformatf("%s/d%0d/tick_overrun", tag, d), 256'(ovr), 256'(movr));
    checkOutput($sformatf("%s/d%0d/cmd_ready", tag, d), 256'(rdy), 256'(mpos < 0));
  endtask

  task automatic compareModel(input string tag);
    compareOne(tag, 0, data0, run0, wrap0, busy0, ovr0, ready0);
    compareOne(tag, 1, data9, run9, wrap9, busy9, ovr9, ready9);
  endtask

  // Drive one cycle of inputs, advance the model and DUTs one edge, then compare.
  task automatic applyStimulus(input string tag, input bit t, input bit v,
                               input logic [1:0] op, input int ch, input int data);
    tick      = t;
    cmd_valid = v;
    cmd_op    = op;
    cmd_ch    = 4'(ch);
    cmd_data  = 16'(data);
    modelStep(t, v, op, ch, data);
    @(posedge clk);
    #1;
    compareModel(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, OP_START, 0, 0);
  endtask

  task automatic doReset();
    tick = 1'b0; cmd_valid = 1'b0; cmd_op = OP_START; cmd_ch = '0; cmd_data = '0;
    reset = 1'b1;
    modelReset();
    #2;
    compareModel("reset");
    checkOutput("reset_data_raw", data0, packVals(0));
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    int         ch;
    int         data;
    int         exp_def;
    int         exp_lim;
    bit         exp_run;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt;
    logic [255:0] exp;

    vecs[0] = '{OP_LOAD,  2,   100,   100,  100, 1'b1};
    vecs[1] = '{OP_LOAD,  4, 65535, 65535, 9999, 1'b1};
    vecs[2] = '{OP_LOAD,  6,  9999,  9999, 9999, 1'b1};
    vecs[3] = '{OP_LOAD,  8, 10000, 10000, 9999, 1'b1};
    vecs[4] = '{OP_CLEAR, 4,     0,     0,    0, 1'b1};
    vecs[5] = '{OP_STOP,  9,     0,     6,    6, 1'b0};
    vecs[6] = '{OP_START, 9,     0,     6,    6, 1'b1};
    vecs[7] = '{OP_LOAD, 15,     0,     0,    0, 1'b1};
    vecs[8] = '{OP_STOP, 15,     0,     0,    0, 1'b0};
    vecs[9] = '{OP_LOAD,  1, 12345, 12345, 9999, 1'b1};

    doReset();

    // One tick: busy for exactly 16 cycles, then every channel +1.
    applyStimulus("tick1", 1'b1, 1'b0, OP_START, 0, 0);
    busy_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      idle("tick1", 1);
      if (busy0) busy_cnt++;
    end
    checkOutput("tick1_busy_cycles", 256'(busy_cnt), 256'(16));
    checkOutput("tick1_data_raw", data0, packVals(1));

    // Stopped channel holds its value through a sweep.
    doReset();
    applyStimulus("stop3", 1'b0, 1'b1, OP_STOP, 3, 0);
    applyStimulus("stop3", 1'b1, 1'b0, OP_START, 0, 0);
    idle("stop3", 17);
    exp = packVals(1);
    exp[3*16 +: 16] = 16'd12;
    checkOutput("stop3_data_raw", data0, exp);
    checkOutput("stop3_run_mask", 256'(run0), 256'(16'hFFF7));

    // Wrap at full range, then CLEAR drops the sticky flag.
    doReset();
    applyStimulus("wrap0", 1'b0, 1'b1, OP_LOAD, 0, 65535);
    applyStimulus("wrap0", 1'b1, 1'b0, OP_START, 0, 0);
    idle("wrap0", 17);
    checkOutput("wrap0_ch0", 256'(data0[15:0]), 256'(0));
    checkOutput("wrap0_flags", 256'(wrap0), 256'(16'h0001));
    applyStimulus("clear0", 1'b0, 1'b1, OP_CLEAR, 0, 0);
    checkOutput("clear0_ch0", 256'(data0[15:0]), 256'(0));
    checkOutput("clear0_flags", 256'(wrap0), 256'(0));

    // LOAD above WRAP_AT saturates, next sweep wraps.
    doReset();
    applyStimulus("sat5", 1'b0, 1'b1, OP_LOAD, 5, 12000);
    checkOutput("sat5_lim_ch5", 256'(data9[5*16 +: 16]), 256'(9999));
    checkOutput("sat5_def_ch5", 256'(data0[5*16 +: 16]), 256'(12000));
    applyStimulus("sat5", 1'b1, 1'b0, OP_START, 0, 0);
    idle("sat5", 17);
    checkOutput("sat5_lim_wrapped", 256'(data9[5*16 +: 16]), 256'(0));
    checkOutput("sat5_lim_flag", 256'(wrap9[5]), 256'(1));
    checkOutput("sat5_def_inc", 256'(data0[5*16 +: 16]), 256'(12001));

    // Three ticks: two sweeps, third tick dropped and flagged.
    doReset();
    applyStimulus("ovr", 1'b1, 1'b0, OP_START, 0, 0);
    idle("ovr", 4);
    applyStimulus("ovr", 1'b1, 1'b0, OP_START, 0, 0);
    idle("ovr", 2);
    applyStimulus("ovr", 1'b1, 1'b0, OP_START, 0, 0);
    idle("ovr", 40);
    checkOutput("ovr_data_raw", data0, packVals(2));
    checkOutput("ovr_flag", 256'(ovr0), 256'(1));

    // Held command stalls through a sweep and executes once idle.
    doReset();
    applyStimulus("stall", 1'b1, 1'b0, OP_START, 0, 0);
    idle("stall", 1);
    for (int i = 0; i < 20; i++) applyStimulus("stall", 1'b0, 1'b1, OP_LOAD, 2, 777);
    checkOutput("stall_ch2", 256'(data0[2*16 +: 16]), 256'(777));

    // Command + tick together, then async reset mid-sweep at index 7.
    doReset();
    applyStimulus("midrst", 1'b1, 1'b1, OP_LOAD, 7, 500);
    idle("midrst", 8);
    checkOutput("midrst_busy", 256'(busy0), 256'(1));
    checkOutput("midrst_ch6", 256'(data0[6*16 +: 16]), 256'(10));
    checkOutput("midrst_ch7", 256'(data0[7*16 +: 16]), 256'(500));
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("midrst_data_raw", data0, packVals(0));
    checkOutput("midrst_ready", 256'(ready0), 256'(1));
    checkOutput("midrst_busy_low", 256'(busy0), 256'(0));
    checkOutput("midrst_run", 256'(run0), 256'(16'hFFFF));
    compareModel("midrst");
    #1;
    reset = 1'b0;

    // Table-driven command vectors.
    doReset();
    foreach (vecs[k]) begin
      applyStimulus($sformatf("vec%0d", k), 1'b0, 1'b1, vecs[k].op, vecs[k].ch, vecs[k].data);
      checkOutput($sformatf("vec%0d_def", k), 256'(data0[vecs[k].ch*16 +: 16]), 256'(vecs[k].exp_def));
      checkOutput($sformatf("vec%0d_lim", k), 256'(data9[vecs[k].ch*16 +: 16]), 256'(vecs[k].exp_lim));
      checkOutput($sformatf("vec%0d_run", k), 256'(run0[vecs[k].ch]), 256'(vecs[k].exp_run));
    end

    // Randomized traffic against the model.
    doReset();
    for (int n = 0; n < 800; n++) begin
      bit t, v;
      int data;
      t = ($urandom_range(0, 9) == 0);
      v = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       data = $urandom_range(65530, 65535);
        1:       data = $urandom_range(9995, 10005);
        2:       data = $urandom_range(0, 20);
        default: data = $urandom_range(0, 65535);
      endcase
      applyStimulus("rand", t, v, 2'($urandom_range(0, 3)), $urandom_range(0, 15), data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
